// File: rtl/vga_fb_scheduler.sv
// Frame-buffer RAM scheduler: VGA pixel prefetch FIFO plus one write port sharing a single-port RAM.
// Define VGA_FB_UNDERFLOW_CNT_EN to add the saturating 16-bit underflow_cnt output.
module vga_fb_scheduler #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LOW_WATER = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_en,
    input  logic              need_pixel,
    output logic [7:0]        pixel_out,
    output logic              underflow,
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    output logic [15:0]       underflow_cnt,
`endif
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready
);
    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam int unsigned       LVL_W     = $clog2(DEPTH + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LOW_L     = LVL_W'(LOW_WATER);

    logic [7:0]        fifo_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d, occ;
    logic [ADDR_W-1:0] fptr_q, fptr_d;
    logic              fetch_done_q, fetch_done_d;
    logic              rd_ret_q, rd_ret_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        pixel_q, pixel_d;
    logic              underflow_q, underflow_d;
    logic              rd_grant, wr_grant, push, pop;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    logic [15:0]       ucnt_q, ucnt_d;

    assign underflow_cnt = ucnt_q;
`endif

    // Reads in flight: one on the RAM bus (mem_rd_q) and one returning data (rd_ret_q).
    always_comb begin
        occ = level_q + {{(LVL_W-1){1'b0}}, mem_rd_q} + {{(LVL_W-1){1'b0}}, rd_ret_q};
        rd_grant = !frame_start && !fetch_done_q && (occ < DEPTH_L) &&
                   ((level_q < LOW_L) || !wr_valid);
        wr_grant = !frame_start && !rd_grant && wr_valid;
        push     = rd_ret_q && !frame_start;
        pop      = pix_en && need_pixel && !frame_start && (level_q != '0);
    end

    always_comb begin
        fptr_d       = fptr_q;
        fetch_done_d = fetch_done_q;
        mem_rd_d     = rd_grant;
        mem_wr_d     = wr_grant;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        // A read on the bus during frame_start belongs to the old frame; drop its data.
        rd_ret_d     = mem_rd_q && !frame_start;
        if (frame_start) begin
            fptr_d       = '0;
            fetch_done_d = 1'b0;
        end else if (rd_grant) begin
            fptr_d       = fptr_q + ADDR_W'(1);
            fetch_done_d = (fptr_q == LAST_ADDR);
        end
        if (rd_grant) begin
            mem_addr_d = fptr_q;
        end else if (wr_grant) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        pixel_d     = pixel_q;
        underflow_d = underflow_q;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        ucnt_d      = ucnt_q;
`endif
        if (frame_start) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            pixel_d     = '0;
            underflow_d = 1'b0;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
            ucnt_d      = '0;
`endif
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            level_d = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
            if (pix_en) begin
                if (!need_pixel) begin
                    pixel_d = '0;
                end else if (pop) begin
                    pixel_d = fifo_q[rptr_q];
                end else begin
                    pixel_d     = '0;
                    underflow_d = 1'b1;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
                    if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            fptr_q       <= '0;
            fetch_done_q <= 1'b1;
            rd_ret_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            pixel_q      <= '0;
            underflow_q  <= 1'b0;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
            ucnt_q       <= '0;
`endif
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            fptr_q       <= fptr_d;
            fetch_done_q <= fetch_done_d;
            rd_ret_q     <= rd_ret_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            pixel_q      <= pixel_d;
            underflow_q  <= underflow_d;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
            ucnt_q       <= ucnt_d;
`endif
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pixel_out = pixel_q;
    assign underflow = underflow_q;
    assign wr_ready  = wr_grant;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: a reduced 64x8 frame, a behavioural RAM and a
// transaction-level model of arbitration, fetch order, FIFO level and pixel stream.
module tb_vga_fb_scheduler;
    localparam int H     = 64;
    localparam int V     = 8;
    localparam int AW    = 19;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int TOTAL = H * V;

    logic          clk, rst, frame_start, pix_en, need_pixel;
    logic [7:0]    pixel_out;
    logic          underflow;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_cnt;
`endif
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;

    logic [7:0]    wmem [int];
    int            n_checks, n_err;

    // Reference model state
    int            lvl, fetch_cnt, pop_k, ufc;
    bit            rd0, rdm1, fdone, uf;
    logic [7:0]    px;

    vga_fb_scheduler #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .LOW_WATER(LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_en       (pix_en),
        .need_pixel   (need_pixel),
        .pixel_out    (pixel_out),
        .underflow    (underflow),
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        .underflow_cnt(underflow_cnt),
`endif
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: unwritten locations hold addr[7:0].
    always @(posedge clk) begin
        if (mem_wr) wmem[int'(mem_addr)] = mem_wdata;
        if (mem_rd) mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)] : mem_addr[7:0];
    end

    function automatic logic [7:0] exp_pix(input int k);
        if (wmem.exists(k)) return wmem[k];
        return 8'(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lvl = 0; fetch_cnt = 0; pop_k = 0; ufc = 0;
        rd0 = 0; rdm1 = 0; fdone = 1; uf = 0; px = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pixel"}, 32'(pixel_out), 32'h0);
        chk({tag, "_uf"}, 32'(underflow), 32'h0);
        chk({tag, "_rd"}, 32'(mem_rd), 32'h0);
        chk({tag, "_wr"}, 32'(mem_wr), 32'h0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'h0);
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        chk({tag, "_ucnt"}, 32'(underflow_cnt), 32'h0);
`endif
    endtask

    // One clock cycle: drive inputs, predict the grant and the resulting state, compare.
    task automatic cycle(input bit fs, input bit pe, input bit np, input bit wv,
                         input logic [AW-1:0] wa, input logic [7:0] wd);
        bit g_rd, g_wr, pop;
        int occ;
        frame_start = fs; pix_en = pe; need_pixel = np;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        occ  = lvl + int'(rd0) + int'(rdm1);
        g_rd = !fs && !fdone && occ < DEPTH && (lvl < LW || !wv);
        g_wr = !fs && !g_rd && wv;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(g_wr));
        pop = 0;
        if (fs) begin
            px = 8'h00; uf = 0; ufc = 0; lvl = 0; pop_k = 0;
            fetch_cnt = 0; fdone = 0;
        end else begin
            if (pe && np) begin
                if (lvl > 0) begin
                    px = exp_pix(pop_k); pop_k++; pop = 1;
                end else begin
                    px = 8'h00; uf = 1;
                    if (ufc < 65535) ufc++;
                end
            end else if (pe) begin
                px = 8'h00;
            end
            lvl = lvl + int'(rdm1) - int'(pop);
        end
        @(posedge clk);
        #1;
        chk("mem_rd", 32'(mem_rd), 32'(g_rd));
        chk("mem_wr", 32'(mem_wr), 32'(g_wr));
        if (g_rd) begin
            chk("rd_addr", 32'(mem_addr), 32'(fetch_cnt));
            fetch_cnt++;
            if (fetch_cnt == TOTAL) fdone = 1;
        end
        if (g_wr) begin
            chk("wr_addr", 32'(mem_addr), 32'(wa));
            chk("wr_data", 32'(mem_wdata), 32'(wd));
        end
        chk("pixel_out", 32'(pixel_out), 32'(px));
        chk("underflow", 32'(underflow), 32'(uf));
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        chk("underflow_cnt", 32'(underflow_cnt), 32'(ufc));
`endif
        rdm1 = fs ? 1'b0 : rd0;
        rd0  = g_rd;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [7:0]    rdat;
        bit            rv, rpe;
        n_checks = 0; n_err = 0;
        rst = 1'b0; frame_start = 0; pix_en = 0; need_pixel = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (4) cycle(0, 0, 0, 0, '0, '0);

        // Fill after frame_start: reads 0..7 back to back, then stop at full.
        cycle(1, 0, 0, 0, '0, '0);
        repeat (14) cycle(0, 0, 0, 0, '0, '0);

        // Write granted against a full FIFO.
        cycle(0, 0, 0, 1, AW'(32'h100), 8'hA5);
        cycle(0, 0, 0, 0, '0, '0);

        // Continuous display with concurrent random writes outside the frame.
        for (int i = 0; i < 120; i++) begin
            rv   = ($urandom_range(0, 1) == 1);
            ra   = AW'(32'h70000 + $urandom_range(0, 4095));
            rdat = 8'($urandom_range(0, 255));
            cycle(0, 1, 1, rv, ra, rdat);
        end
        // Rest of the frame with a bursty pixel strobe, through end of fetch.
        for (int i = 0; i < 700; i++) begin
            rv   = ($urandom_range(0, 1) == 1);
            rpe  = ($urandom_range(0, 3) != 0);
            ra   = AW'(32'h70000 + $urandom_range(0, 4095));
            rdat = 8'($urandom_range(0, 255));
            cycle(0, rpe, pop_k < TOTAL, rv, ra, rdat);
        end
        chk("frame_no_underflow", 32'(underflow), 32'h0);

        // Pop one cycle after frame_start finds the FIFO empty.
        cycle(1, 0, 0, 0, '0, '0);
        cycle(0, 1, 1, 0, '0, '0);
        chk("uf_set", 32'(underflow), 32'h1);
        chk("uf_pixel", 32'(pixel_out), 32'h0);
        cycle(1, 0, 0, 0, '0, '0);
        chk("uf_cleared", 32'(underflow), 32'h0);

        // frame_start while a read is on the bus: its data must not land in the FIFO.
        cycle(0, 0, 0, 0, '0, '0);
        chk("kill_rd_on_bus", 32'(mem_rd), 32'h1);
        cycle(1, 0, 0, 0, '0, '0);
        cycle(0, 0, 0, 0, '0, '0);
        cycle(0, 1, 1, 0, '0, '0);
        chk("kill_level_zero", 32'(underflow), 32'h1);
        repeat (12) cycle(0, 1, 1, 0, '0, '0);

        // Asynchronous reset in the middle of traffic.
        cycle(1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 30; i++) begin
            rv   = ($urandom_range(0, 1) == 1);
            ra   = AW'(32'h70000 + $urandom_range(0, 4095));
            rdat = 8'($urandom_range(0, 255));
            cycle(0, 1, 1, rv, ra, rdat);
        end
        frame_start = 0; pix_en = 0; need_pixel = 0; wr_valid = 0;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (5) cycle(0, 0, 0, 0, '0, '0);
        cycle(1, 0, 0, 0, '0, '0);
        repeat (12) cycle(0, 0, 0, 0, '0, '0);
        repeat (10) cycle(0, 1, 1, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Frame-buffer memory scheduler for the 640x480 VGA path. Shares one single-port pixel RAM between the display fetch stream and one write requester (drawing engine/CPU). It prefetches pixels into a small FIFO ahead of the VGA driver's pixel demand and hands the 8-bit RGB332 pixel to the driver's `colors` input. Write requests are granted in the gaps.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `ADDR_W`, 19: frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- `DEPTH`, 8: prefetch FIFO entries; power of 2, >= 4.
- `LOW_WATER`, 4: FIFO level below which reads take priority over writes.

Ports:
- `clk` in 1: system clock, same 25 MHz domain as the VGA driver.
- `rst` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at the start of each frame (vsync rising edge).
- `pix_en` in 1: pixel strobe; one display pixel per asserted cycle.
- `need_pixel` in 1: high while the driver is in the active area.
- `pixel_out` out 8: registered pixel to the driver `colors`.
- `underflow` out 1: sticky flag; set on a pop from an empty FIFO, cleared by `frame_start`.
- `mem_rd` out 1: registered read strobe.
- `mem_wr` out 1: registered write strobe.
- `mem_addr` out ADDR_W: registered address.
- `mem_wdata` out 8: registered write data.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_rd`.
- `wr_valid` in 1, `wr_addr` in ADDR_W, `wr_data` in 8: write request.
- `wr_ready` out 1: combinational grant; the transfer occurs when `wr_valid` and `wr_ready` are both high.

## Operation
- **Fetch pointer** `fptr` (ADDR_W bits) runs from 0 to H_ACTIVE*V_ACTIVE-1.
  - Increments on each issued read.
  - Saturates when it reaches H_ACTIVE*V_ACTIVE; `fetch_done` = 1 and no further reads are issued.
  - `frame_start` reloads `fptr` to 0 and clears `fetch_done`.
- **In-flight count**: `occ = FIFO level + reads in flight` (0..DEPTH). A read may issue only if `occ < DEPTH`.
- **Arbitration** is evaluated each cycle; exactly one decision is made.
  - READ if `!fetch_done`, `occ < DEPTH`, and (`level < LOW_WATER` or `!wr_valid`).
  - Otherwise WRITE if `wr_valid`; `wr_ready` = 1 in this cycle.
  - Otherwise IDLE.
  - Consequence: the writer is never starved while the FIFO holds >= LOW_WATER entries.
- **FIFO push** occurs when read data returns. Data returning from a read issued before the latest `frame_start` is discarded; a one-cycle kill tag on the in-flight read implements this.
- **Pop** occurs when `pix_en && need_pixel`.
  - Non-empty FIFO: `pixel_out` <= head.
  - Empty FIFO: `pixel_out` <= 0 and `underflow` <= 1.
- **Outside the active area** (`pix_en && !need_pixel`): `pixel_out` <= 0.
- **`frame_start`**:
  - Flushes the FIFO (level 0).
  - Clears `underflow`.
  - Has priority over a same-cycle pop; that pop is ignored, `pixel_out` <= 0, and no underflow is recorded.
  - Suppresses any arbitration grant in its cycle: no read, `wr_ready` = 0.
- **Write addresses** are not range-checked. Writes to pixels already prefetched are not coherent; the stale value is displayed this frame.

## Timing
- Grant decision in cycle t. In cycle t+1, `mem_rd`/`mem_wr`, `mem_addr` and `mem_wdata` are driven. `mem_rdata` is sampled at t+2; the FIFO level increments at the end of t+2.
- Read-to-display latency: 3 cycles minimum. With DEPTH=8 the FIFO is full within DEPTH+2 = 10 cycles of `frame_start` when there is no write traffic.
- The memory strobes are single-cycle, with at most one per cycle; `mem_rd` and `mem_wr` are never high together.
- Reset values:
  - `pixel_out`, `mem_addr` and `mem_wdata` = 0.
  - `mem_rd`, `mem_wr`, `underflow` and `wr_ready` = 0.
  - FIFO empty, `fptr` = 0, `fetch_done` = 1 (no fetch until the first `frame_start`).
- Reset asserted mid-operation clears everything immediately and asynchronously. In-flight read data arriving after reset release is ignored.

## Configuration
- Macro `VGA_FB_UNDERFLOW_CNT_EN`.
- **Defined**: adds output port `underflow_cnt` (16 bits).
  - Increments on every empty pop and saturates at 16'hFFFF.
  - Cleared by `frame_start` and by reset.
- **Undefined**: the port and counter are absent; only the sticky `underflow` flag exists.

## Test plan
- Reset, then `frame_start` pulse, with no writes and `pix_en` = 0:
  - `mem_rd` is asserted with addresses 0..7 on consecutive cycles.
  - Fetch stops with FIFO level 8.
  - `wr_ready` = 0 throughout.
- FIFO full, `wr_valid` = 1, `wr_addr` = 0x100, `wr_data` = 0xA5:
  - `wr_ready` = 1 in the same cycle.
  - Next cycle: `mem_wr` = 1, `mem_addr` = 0x100, `mem_wdata` = 0xA5.
- RAM preloaded with data = addr[7:0]; `pix_en` and `need_pixel` held high continuously after fill:
  - `pixel_out` sequence is 0x00, 0x01, 0x02, ... with no underflow.
  - With concurrent `wr_valid`, writes are granted only while level >= 4.
- `need_pixel` asserted 1 cycle after `frame_start`:
  - `pixel_out` = 0, `underflow` = 1.
  - With the macro defined, `underflow_cnt` = 1.
  - The next `frame_start` clears both.
- `frame_start` in the cycle after a read issue: the returning data is dropped, the FIFO level stays 0, and the next read address is 0.
- Run a full frame of 307200 pops:
  - The last read address is 307199, then `fetch_done` = 1 and no further `mem_rd` is issued.
  - The next `frame_start` restarts fetching at address 0.
